// File: rtl/seg_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_pkg
// Shared types and constants for the seven-segment scan controller.
//   scan_state_e : scan FSM states (IDLE, BLANK, SHOW)
//   SEG_BLANK    : active-low code with every segment dark
//   SEG_DASH     : active-low code with only segment g lit
//   BCD_MAX      : largest legal BCD digit value
// ---------------------------------------------------------------------------
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [3:0] BCD_MAX   = 4'd9;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
// Bundles the application-side and display-side signals of the scan
// controller.
//   enable     : scanning runs while high
//   load       : single-cycle strobe capturing digits_in
//   digits_in  : packed BCD, digit k at [4k+3:4k]
//   digit_bcd  : digit presented to the shared external decoder
//   seg_in     : active-low segments returned by the shared decoder
//   seg_out    : registered active-low segment pins
//   an_n       : registered active-low anode enables
//   frame_done : one-cycle pulse after the last digit of a frame
// Modports: master = application/decoder side, slave = scan controller.
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [3:0]                digit_bcd;
  logic [6:0]                seg_in;
  logic [6:0]                seg_out;
  logic [NUM_DIGITS-1:0]     an_n;
  logic                      frame_done;

  modport master (
    output enable, load, digits_in, seg_in,
    input  digit_bcd, seg_out, an_n, frame_done
  );

  modport slave (
    input  enable, load, digits_in, seg_in,
    output digit_bcd, seg_out, an_n, frame_done
  );

endinterface

// File: rtl/seg_scan_ctrl_lz_mask.sv
// ---------------------------------------------------------------------------
// seg_lz_mask
// Combinational segment masking for the digit currently being scanned.
//   shadow_i : packed BCD frame contents, digit k at [4k+3:4k]
//   idx_i    : position being scanned
//   seg_i    : active-low segments from the shared decoder
//   seg_o    : active-low segments after masking
// Rules, first match wins: a non-BCD digit shows a dash; with LZ_BLANK set,
// a zero at a non-zero position whose higher digits are all zero is dark;
// otherwise the decoder output passes through.
// ---------------------------------------------------------------------------
module seg_lz_mask
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2,
  parameter int LZ_BLANK   = 1
) (
  input  logic [4*NUM_DIGITS-1:0] shadow_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [6:0]              seg_i,
  output logic [6:0]              seg_o
);

  logic [3:0] digit;
  logic       upperZero;

  // upperZero is true when this position and every position above it hold
  // zero, i.e. the digit is a leading zero of the displayed number.
  always_comb begin
    digit     = shadow_i[{idx_i, 2'b00} +: 4];
    upperZero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx_i) && shadow_i[4*k +: 4] != 4'd0) begin
        upperZero = 1'b0;
      end
    end
    if (digit > BCD_MAX) begin
      seg_o = SEG_DASH;
    end else if (LZ_BLANK != 0 && idx_i != '0 && upperZero) begin
      seg_o = SEG_BLANK;
    end else begin
      seg_o = seg_i;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One external BCD decoder is shared by all positions: digit_bcd is driven
// during the blanking gap so seg_in is settled before the anode turns on.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : seg_scan_ctrl_if slave modport (load/enable in, display out)
// New digits are staged in a pending register and only copied into the
// displayed shadow copy at a frame boundary, so a frame never tears.
// ---------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 3000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pendValid_q, pendValid_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frameDone_q, frameDone_d;
  logic                    boundary;
  logic [6:0]              maskedSeg;

  seg_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS),
    .IDX_W      (IDX_W),
    .LZ_BLANK   (LZ_BLANK)
  ) u_mask (
    .shadow_i (shadow_q),
    .idx_i    (idx_q),
    .seg_i    (bus.seg_in),
    .seg_o    (maskedSeg)
  );

  // State and output registers; everything visible on the pins comes from
  // here, so there is no combinational path from seg_in to seg_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      pending_q   <= '0;
      pendValid_q <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      pendValid_q <= pendValid_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frameDone_q <= frameDone_d;
    end
  end

  // Next-state logic. Outputs are computed from the next state so the
  // registered pins line up exactly with the state they describe.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    pendValid_d = pendValid_q;
    seg_d       = SEG_BLANK;
    an_d        = '1;
    frameDone_d = 1'b0;
    boundary    = 1'b0;

    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          idx_d    = '0;
          cnt_d    = '0;
          boundary = 1'b1;
        end
        BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              idx_d       = '0;
              frameDone_d = 1'b1;
              boundary    = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // A load coinciding with a frame boundary bypasses the pending stage.
    if (boundary) begin
      if (bus.load) begin
        shadow_d = bus.digits_in;
      end else if (pendValid_q) begin
        shadow_d = pending_q;
      end
      pendValid_d = 1'b0;
    end else if (bus.load) begin
      pending_d   = bus.digits_in;
      pendValid_d = 1'b1;
    end

    // idx is stable across BLANK->SHOW and within SHOW, so idx_q selects
    // the anode and the mask for the slot being entered.
    if (state_d == SHOW) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = maskedSeg;
    end
  end

  assign bus.digit_bcd  = shadow_q[{idx_q, 2'b00} +: 4];
  assign bus.seg_out    = seg_q;
  assign bus.an_n       = an_q;
  assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL=4, BLANK=2,
// LZ_BLANK=1. A shared BCD decoder is modelled here and fed from digit_bcd.
// A frame is 24 clocks; within a frame cycle c sits in slot c/6, with the
// first two cycles of each slot blanked and the next four showing.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  logic clk;
  logic rst_n;
  int   checkCount = 0;
  int   errorCount = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2),
    .LZ_BLANK     (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared active-low decoder, segment order g..a on bits 6..0.
  function automatic logic [6:0] decodeBcd(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign bus.seg_in = decodeBcd(bus.digit_bcd);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check is counted and mismatches reported.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle load pulse, driven from a falling edge.
  task automatic applyStimulus(input logic [15:0] value);
    bus.load      = 1'b1;
    bus.digits_in = value;
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  // Checks one full frame starting at its first BLANK cycle. expSegs holds
  // the expected SHOW code of slot k at [7k+6:7k]. An optional load is
  // pulsed during cycle loadAt. Ends positioned at the next frame start.
  task automatic checkFrame(input string name, input logic [27:0] expSegs,
                            input logic expFd0, input int loadAt,
                            input logic [15:0] loadVal);
    int         slot;
    int         phase;
    logic [3:0] expAn;
    logic [6:0] expSeg;
    for (int c = 0; c < 24; c++) begin
      slot   = c / 6;
      phase  = c % 6;
      expAn  = (phase < 2) ? 4'hF : ~(4'b0001 << slot);
      expSeg = (phase < 2) ? 7'h7F : expSegs[slot*7 +: 7];
      checkOutput($sformatf("%s an_n c%0d", name, c), 32'(bus.an_n), 32'(expAn));
      checkOutput($sformatf("%s seg_out c%0d", name, c), 32'(bus.seg_out), 32'(expSeg));
      checkOutput($sformatf("%s frame_done c%0d", name, c), 32'(bus.frame_done),
                  (c == 0) ? 32'(expFd0) : 32'd0);
      if (c == loadAt) begin
        bus.load      = 1'b1;
        bus.digits_in = loadVal;
      end
      @(negedge clk);
      bus.load = 1'b0;
    end
    checkOutput($sformatf("%s frame_done wrap", name), 32'(bus.frame_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = 16'h0000;
    repeat (3) @(negedge clk);

    checkOutput("reset an_n", 32'(bus.an_n), 32'hF);
    checkOutput("reset seg_out", 32'(bus.seg_out), 32'h7F);
    checkOutput("reset digit_bcd", 32'(bus.digit_bcd), 32'h0);
    checkOutput("reset frame_done", 32'(bus.frame_done), 32'h0);

    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'h1234);
    checkOutput("idle an_n", 32'(bus.an_n), 32'hF);

    // Start scanning; the pending 1234 is applied on IDLE->BLANK.
    bus.enable = 1'b1;
    @(negedge clk);
    checkOutput("first digit_bcd", 32'(bus.digit_bcd), 32'h4);
    checkFrame("f1234", {decodeBcd(4'd1), decodeBcd(4'd2), decodeBcd(4'd3), decodeBcd(4'd4)},
               1'b0, 3, 16'h0050);

    // Leading zeros in positions 3 and 2 are dark; position 0 keeps its 0.
    checkFrame("f0050", {7'h7F, 7'h7F, decodeBcd(4'd5), decodeBcd(4'd0)},
               1'b1, 3, 16'h00A7);

    // Non-BCD digit shows a dash; mid-frame load at idx=1 must not tear.
    checkFrame("f00A7", {7'h7F, 7'h7F, 7'h3F, decodeBcd(4'd7)},
               1'b1, 8, 16'h9999);

    // Load in the boundary cycle goes straight into the next frame.
    checkFrame("f9999", {decodeBcd(4'd9), decodeBcd(4'd9), decodeBcd(4'd9), decodeBcd(4'd9)},
               1'b1, 23, 16'h0008);
    checkFrame("f0008", {7'h7F, 7'h7F, 7'h7F, decodeBcd(4'd8)},
               1'b1, -1, 16'h0000);

    // Drop enable in the middle of SHOW for idx=2.
    repeat (15) @(negedge clk);
    checkOutput("pre-disable an_n", 32'(bus.an_n), 32'hB);
    bus.enable = 1'b0;
    @(negedge clk);
    checkOutput("disable an_n", 32'(bus.an_n), 32'hF);
    checkOutput("disable seg_out", 32'(bus.seg_out), 32'h7F);
    checkOutput("disable digit_bcd", 32'(bus.digit_bcd), 32'h8);
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    checkFrame("reenable", {7'h7F, 7'h7F, 7'h7F, decodeBcd(4'd8)},
               1'b0, -1, 16'h0000);

    // Asynchronous reset between edges while showing idx=0.
    repeat (3) @(negedge clk);
    checkOutput("pre-reset an_n", 32'(bus.an_n), 32'hE);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset an_n", 32'(bus.an_n), 32'hF);
    checkOutput("async reset seg_out", 32'(bus.seg_out), 32'h7F);
    checkOutput("async reset digit_bcd", 32'(bus.digit_bcd), 32'h0);
    checkOutput("async reset frame_done", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkFrame("postreset", {7'h7F, 7'h7F, 7'h7F, decodeBcd(4'd0)},
               1'b0, -1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
